// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: PC register, combinational imem read, DEPTH-entry {pc, instr} queue to Decode.
// One-cycle fetch-to-decode latency; fetch stalls only when the queue is full and its head is not popped.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              INCR     = 4,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_disp,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [XLEN-1:0] buf_instr [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push;
  logic            pop;

  // A full queue keeps fetching when its head leaves in the same cycle.
  assign pop  = (count != '0) & dec_ready & ~redirect;
  assign push = ~redirect & ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= redirect_base + redirect_disp;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + XLEN'(INCR);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is not reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= pc;
      buf_instr[wr_ptr] <= imem_data;
    end
  end

  assign imem_addr = pc;
  assign dec_valid = (count != '0);
  assign dec_pc    = dec_valid ? buf_pc[rd_ptr]    : '0;
  assign dec_instr = dec_valid ? buf_instr[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage against a queue-based reference model.
module tb_fetch_queue_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_base = '0;
  logic [31:0] redirect_disp = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch PC plus a FIFO of {pc, instr} pairs.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ KEY;

  fetch_queue_stage dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_base(redirect_base),
    .redirect_disp(redirect_disp), .imem_addr(imem_addr), .imem_data(imem_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .count(count)
  );

  function automatic logic        e_valid();  return m_q.size() != 0; endfunction
  function automatic logic [31:0] e_pc();     return m_q.size() != 0 ? m_q[0][63:32] : 32'h0; endfunction
  function automatic logic [31:0] e_instr();  return m_q.size() != 0 ? m_q[0][31:0] : 32'h0; endfunction
  function automatic logic [2:0]  e_count();  return 3'(m_q.size()); endfunction

  function automatic void model_step(input logic r, input logic [31:0] b, input logic [31:0] d,
                                     input logic rdy);
    logic popped;
    logic was_full;
    if (r) begin
      m_q.delete();
      m_pc = b + d;
    end else begin
      was_full = (m_q.size() == DEPTH);
      popped   = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (!was_full || popped) begin
        m_q.push_back({m_pc, m_pc ^ KEY});
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  // Drive one cycle of inputs, update the model at the edge, return at the following negedge.
  task automatic cycle(input logic r, input logic [31:0] b, input logic [31:0] d, input logic rdy);
    redirect = r; redirect_base = b; redirect_disp = d; dec_ready = rdy;
    @(posedge clk);
    model_step(r, b, d, rdy);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    m_q.delete();
    m_pc = 32'h0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dec_ready = 1'b1;
    @(negedge clk);
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %h want 0", dec_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    tests++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
      fails++; $display("FAIL reset_head got pc %h instr %h want 0 0", dec_pc, dec_instr);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      tests++; if (dec_pc !== 32'(4 * i) || dec_instr !== (32'(4 * i) ^ KEY) || count !== 3'd1) begin
        fails++; $display("FAIL stream[%0d] got pc %h instr %h cnt %0d want pc %h instr %h cnt 1",
                          i, dec_pc, dec_instr, count, 32'(4 * i), 32'(4 * i) ^ KEY);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL bp_count got %0d want 4", count); end
    tests++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL bp_pc got %h want 10", imem_addr); end
    tests++; if (dec_pc !== 32'h0 || dec_valid !== 1'b1) begin
      fails++; $display("FAIL bp_head got pc %h valid %b want 0 1", dec_pc, dec_valid);
    end
    // Full queue popping every cycle: pointers wrap while count stays at DEPTH.
    for (int i = 0; i < 10; i++) begin
      want = 32'(4 * i);
      tests++; if (dec_pc !== want || dec_instr !== (want ^ KEY) || count !== 3'd4) begin
        fails++; $display("FAIL drain[%0d] got pc %h instr %h cnt %0d want pc %h cnt 4",
                          i, dec_pc, dec_instr, count, want);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL redir_pre_count got %0d want 3", count); end
    cycle(1'b1, 32'h100, 32'hFFFF_FFF0, 1'(($urandom) & 1));
    tests++; if (count !== 3'd0 || dec_valid !== 1'b0 || dec_pc !== 32'h0) begin
      fails++; $display("FAIL redir_flush got cnt %0d valid %b pc %h want 0 0 0", count, dec_valid, dec_pc);
    end
    tests++; if (imem_addr !== 32'hF0) begin fails++; $display("FAIL redir_addr got %h want f0", imem_addr); end
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    tests++; if (dec_pc !== 32'hF0 || dec_valid !== 1'b1 || dec_instr !== (32'hF0 ^ KEY)) begin
      fails++; $display("FAIL redir_target got pc %h valid %b want f0 1", dec_pc, dec_valid);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 32'h0, 1'b1);
    cycle(1'b1, 32'h0, 32'h80, 1'b1);
    tests++; if (count !== 3'd0 || dec_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_flush got cnt %0d valid %b want 0 0", count, dec_valid);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    tests++; if (dec_pc !== 32'h80 || count !== 3'd1) begin
      fails++; $display("FAIL b2b_target got pc %h cnt %0d want 80 1", dec_pc, count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL arst_pre_count got %0d want 2", count); end
    #2 rst = 1'b1;
    #1;
    tests++; if (dec_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL arst_now got valid %b cnt %0d addr %h want 0 0 0", dec_valid, count, imem_addr);
    end
    @(negedge clk);
    m_q.delete();
    m_pc = 32'h0;
    rst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    tests++; if (dec_pc !== 32'h0 || dec_valid !== 1'b1) begin
      fails++; $display("FAIL arst_first got pc %h valid %b want 0 1", dec_pc, dec_valid);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    cycle(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    tests++; if (dec_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first got %h want fffffffc", dec_pc); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    tests++; if (dec_pc !== 32'h0 || dec_instr !== KEY) begin
      fails++; $display("FAIL wrap_second got pc %h instr %h want 0 %h", dec_pc, dec_instr, KEY);
    end
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 9) == 0);
      cycle(r, $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
      tests++;
      if (dec_valid !== e_valid() || dec_pc !== e_pc() || dec_instr !== e_instr() ||
          count !== e_count() || imem_addr !== m_pc) begin
        fails++;
        $display("FAIL rand[%0d] got v%b pc %h in %h c%0d a %h want v%b pc %h in %h c%0d a %h",
                 i, dec_valid, dec_pc, dec_instr, count, imem_addr,
                 e_valid(), e_pc(), e_instr(), e_count(), m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_async_reset();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
